// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//
// In-order FIFO between the fetch-side predictor lookup and the TAGE update
// port. Each issued prediction {idx, taken} is queued. In-order resolutions
// from execute are matched against the head entry. Each resolution produces
// one registered update beat {idx, actual direction, correct flag}.
//
// Optional feature macro: BRQ_FLUSH_EN
//   defined   : a mispredicting pop also discards every younger entry, and a
//               push in the same cycle is dropped as wrong-path.
//   undefined : a mispredict pops only the head entry.
//
// Handshake: a push happens on a rising edge where pred_valid_i && pred_ready_o.
// pred_ready_o depends only on the registered occupancy (count < DEPTH). It
// never depends on a same-cycle pop. Resolutions have no ready. A resolution
// that arrives with the queue empty is dropped and latches res_err_o.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   pred_valid_i/ready_o   prediction push handshake
//   pred_idx_i/taken_i     pushed branch index and predicted direction
//   res_valid_i/taken_i    head-branch resolution and actual direction
//   upd_valid_o            one-cycle update beat strobe
//   upd_idx_o              index of the resolved branch (held when idle)
//   br_result_o            actual direction (held when idle)
//   correct_o              predicted == actual (held when idle)
//   count_o                occupied entries
//   res_err_o              sticky: resolution seen with the queue empty
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     pred_valid_i,
   output logic                     pred_ready_o,
   input  logic [IDX_W-1:0]         pred_idx_i,
   input  logic                     pred_taken_i,
   input  logic                     res_valid_i,
   input  logic                     res_taken_i,
   output logic                     upd_valid_o,
   output logic [IDX_W-1:0]         upd_idx_o,
   output logic                     br_result_o,
   output logic                     correct_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     res_err_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Entry storage is not reset. Occupancy alone decides validity.
   logic [IDX_W-1:0] r_idx_mem   [DEPTH];
   logic             r_taken_mem [DEPTH];

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             r_upd_valid;
   logic [IDX_W-1:0] r_upd_idx;
   logic             r_br_result;
   logic             r_correct;
   logic             r_res_err;

   logic             w_push;
   logic             w_push_eff;
   logic             w_pop;
   logic             w_correct;
   logic             w_flush;
   logic             w_res_empty;

   assign pred_ready_o = (r_count < CNT_W'(DEPTH));
   assign w_push       = pred_valid_i && pred_ready_o;
   assign w_pop        = res_valid_i && (r_count != '0);
   assign w_res_empty  = res_valid_i && (r_count == '0);
   assign w_correct    = (r_taken_mem[r_head] == res_taken_i);

`ifdef BRQ_FLUSH_EN
   // A mispredicted head means every younger entry was fetched down the wrong path.
   assign w_flush = w_pop && !w_correct;
`else
   assign w_flush = 1'b0;
`endif

   // A push that coincides with a flush is wrong-path and is dropped.
   assign w_push_eff = w_push && !w_flush;

   always_ff @(posedge clk_i) begin
      if (w_push_eff) begin
         r_idx_mem[r_tail]   <= pred_idx_i;
         r_taken_mem[r_tail] <= pred_taken_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_upd_valid <= 1'b0;
         r_upd_idx   <= '0;
         r_br_result <= 1'b0;
         r_correct   <= 1'b0;
         r_res_err   <= 1'b0;
      end else begin
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end

         if (w_flush) begin
            // Leave the queue empty just past the popped head.
            r_tail  <= r_head + PTR_W'(1);
            r_count <= '0;
         end else begin
            if (w_push_eff) begin
               r_tail <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push_eff) - CNT_W'(w_pop);
         end

         // The update payload holds its last value on cycles without a pop.
         r_upd_valid <= w_pop;
         if (w_pop) begin
            r_upd_idx   <= r_idx_mem[r_head];
            r_br_result <= res_taken_i;
            r_correct   <= w_correct;
         end

         if (w_res_empty) begin
            r_res_err <= 1'b1;
         end
      end
   end

   assign upd_valid_o = r_upd_valid;
   assign upd_idx_o   = r_upd_idx;
   assign br_result_o = r_br_result;
   assign correct_o   = r_correct;
   assign count_o     = r_count;
   assign res_err_o   = r_res_err;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Directed scenarios followed by a randomized run. Every cycle is checked
// against a queue-based reference model of the branch resolve queue. Define
// BRQ_FLUSH_EN for both the bench and the RTL to exercise the flush build.
// ---------------------------------------------------------------------------
module tb_branch_resolve_queue;

   localparam int DEPTH = 16;
   localparam int IDX_W = 32;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic             pred_valid_i = 1'b0;
   logic             pred_ready_o;
   logic [IDX_W-1:0] pred_idx_i = '0;
   logic             pred_taken_i = 1'b0;
   logic             res_valid_i = 1'b0;
   logic             res_taken_i = 1'b0;
   logic             upd_valid_o;
   logic [IDX_W-1:0] upd_idx_o;
   logic             br_result_o;
   logic             correct_o;
   logic [CNT_W-1:0] count_o;
   logic             res_err_o;

   branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .pred_valid_i (pred_valid_i),
      .pred_ready_o (pred_ready_o),
      .pred_idx_i   (pred_idx_i),
      .pred_taken_i (pred_taken_i),
      .res_valid_i  (res_valid_i),
      .res_taken_i  (res_taken_i),
      .upd_valid_o  (upd_valid_o),
      .upd_idx_o    (upd_idx_o),
      .br_result_o  (br_result_o),
      .correct_o    (correct_o),
      .count_o      (count_o),
      .res_err_o    (res_err_o)
   );

   // ---------------- reference model / scoreboard ----------------
   // Each queued entry is {predicted taken, idx}.
   logic [IDX_W:0]   exp_q[$];
   logic             m_upd_valid;
   logic [IDX_W-1:0] m_upd_idx;
   logic             m_br;
   logic             m_corr;
   logic             m_err;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_upd_valid = 1'b0;
      m_upd_idx   = '0;
      m_br        = 1'b0;
      m_corr      = 1'b0;
      m_err       = 1'b0;
   endtask

   task automatic check_outputs();
      check("upd_valid", 64'(upd_valid_o), 64'(m_upd_valid));
      check("upd_idx",   64'(upd_idx_o),   64'(m_upd_idx));
      check("br_result", 64'(br_result_o), 64'(m_br));
      check("correct",   64'(correct_o),   64'(m_corr));
      check("count",     64'(count_o),     64'(exp_q.size()));
      check("res_err",   64'(res_err_o),   64'(m_err));
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge: drive one cycle, advance the model,
   // then check the registered results on the next falling edge.
   task automatic step(input logic pv, input logic [IDX_W-1:0] pidx, input logic pt,
                       input logic rv, input logic rt);
      logic           ready;
      logic           flush;
      logic [IDX_W:0] e;
      pred_valid_i = pv;
      pred_idx_i   = pidx;
      pred_taken_i = pt;
      res_valid_i  = rv;
      res_taken_i  = rt;
      ready = (exp_q.size() < DEPTH);
      check("pred_ready", 64'(pred_ready_o), 64'(ready));
      flush = 1'b0;
      m_upd_valid = 1'b0;
      if (rv && exp_q.size() == 0) m_err = 1'b1;
      if (rv && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         m_upd_valid = 1'b1;
         m_upd_idx   = e[IDX_W-1:0];
         m_br        = rt;
         m_corr      = (e[IDX_W] == rt);
`ifdef BRQ_FLUSH_EN
         flush = !m_corr;
`endif
      end
      if (flush) exp_q.delete();
      else if (pv && ready) exp_q.push_back({pt, pidx});
      @(posedge clk_i);
      @(negedge clk_i);
      check_outputs();
      pred_valid_i = 1'b0;
      res_valid_i  = 1'b0;
   endtask

   // Reset asserted between edges; the clear must be visible before the next edge.
   task automatic async_reset(input logic resolve_during);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      res_valid_i = resolve_during;
      res_taken_i = 1'b1;
      #1;
      model_reset();
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_ready", 64'(pred_ready_o), 64'd1);
      check("rst_upd_valid", 64'(upd_valid_o), 64'd0);
      @(negedge clk_i);
      check("rst_upd_valid_held", 64'(upd_valid_o), 64'd0);
      res_valid_i = 1'b0;
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_outputs();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Reset values
      check("init_count", 64'(count_o), 64'd0);
      check("init_ready", 64'(pred_ready_o), 64'd1);
      check("init_upd_valid", 64'(upd_valid_o), 64'd0);
      check("init_res_err", 64'(res_err_o), 64'd0);
      check_outputs();

      // Single push, resolve two cycles later
      step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("single_idx", 64'(upd_idx_o), 64'h100);
      check("single_correct", 64'(correct_o), 64'd1);
      check("single_count", 64'(count_o), 64'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("single_beat_once", 64'(upd_valid_o), 64'd0);

      // Fill to full, push+pop at full, drain; three rounds to wrap pointers
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < DEPTH; i++)
            step(1'b1, IDX_W'(32'h200 + r * 32 + i), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         check("full_ready", 64'(pred_ready_o), 64'd0);
         step(1'b1, 32'hDEAD, 1'b1, 1'b1, exp_q[0][IDX_W]);
         check("full_pop_count", 64'(count_o), 64'(DEPTH - 1));
         while (exp_q.size() != 0)
            step(1'b0, '0, 1'b0, 1'b1, exp_q[0][IDX_W]);
      end

      // Resolve with empty queue; error stays sticky through valid traffic
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("empty_no_beat", 64'(upd_valid_o), 64'd0);
      check("empty_err", 64'(res_err_o), 64'd1);
      step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, IDX_W'(32'h301 + i), 1'b1, 1'b1, 1'b1);
         check("err_sticky", 64'(res_err_o), 64'd1);
      end

      // Mispredict on the oldest of three entries
      async_reset(1'b0);
      step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("mis_idx", 64'(upd_idx_o), 64'h10);
      check("mis_correct", 64'(correct_o), 64'd0);
`ifdef BRQ_FLUSH_EN
      check("mis_count", 64'(count_o), 64'd0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("mis_next_err", 64'(res_err_o), 64'd1);
      check("mis_next_no_beat", 64'(upd_valid_o), 64'd0);
`else
      check("mis_count", 64'(count_o), 64'd2);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("mis_next_idx", 64'(upd_idx_o), 64'h20);
      check("mis_next_correct", 64'(correct_o), 64'd1);
`endif

      // Mid-cycle reset with five entries in flight
      async_reset(1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b1, IDX_W'(32'h400 + i), 1'b1, 1'b0, 1'b0);
      check("pre_rst_count", 64'(count_o), 64'd5);
      async_reset(1'b1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic rt;
         rt = 1'($urandom_range(0, 1));
         if (exp_q.size() != 0 && $urandom_range(0, 99) < 70) rt = exp_q[0][IDX_W];
         step(1'($urandom_range(0, 99) < 60), IDX_W'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < 50), rt);
         if (i == 300) async_reset(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
